// File: rtl/pcie_tlp_hdr_extract.sv
// pcie_tlp_hdr_extract
//
// Splits an inbound PCIe TLP stream (one DW per AXI-Stream beat) into a
// 128-bit header word and a payload stream. It also checks the header Length
// field against the number of payload DWs actually received.
//
// Header word layout matches tlp_hdr_union_t.whole_: DW0 in [127:96] and
// DW3 in [31:0]. A 3DW header leaves [31:0] at zero.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast : inbound TLP stream, header DW0 first
//   m_hdr/m_hdr_valid/m_hdr_ready     : captured header, held until accepted
//   m_axis_tdata/tvalid/tready/tlast  : payload stream (one register slice)
//   err_len             : 1-cycle pulse, payload length disagrees with header
//   err_trunc           : 1-cycle pulse, tlast arrived inside the header
module pcie_tlp_hdr_extract (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [127:0] m_hdr,
  output logic         m_hdr_valid,
  input  logic         m_hdr_ready,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         err_len,
  output logic         err_trunc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HOUT,
    S_PAY,
    S_DRAIN
  } state_e;

  state_e       state_q;
  logic [127:0] hdr_q;
  logic         hdr_vld_q;
  logic [1:0]   dw_idx_q;    // index of the next header DW to capture
  logic         hdr4_q;      // 4DW header (Fmt[5])
  logic         has_data_q;  // TLP carries payload (Fmt[6])
  logic         hdr_last_q;  // tlast seen on the final header DW
  logic [10:0]  rem_q;       // payload DWs still expected
  logic [31:0]  pay_data_q;
  logic         pay_vld_q;
  logic         pay_last_q;
  logic         err_len_q;
  logic         err_trunc_q;

  logic in_fire;
  logic out_fire;
  logic pay_room;
  logic hdr_final;

  // Length 0 encodes the maximum of 1024 DW.
  function automatic logic [10:0] len_to_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  assign out_fire  = pay_vld_q && m_axis_tready;
  // Register slice: a new beat fits only if the slot is empty or draining now.
  assign pay_room  = !pay_vld_q || m_axis_tready;
  assign hdr_final = hdr4_q ? (dw_idx_q == 2'd3) : (dw_idx_q == 2'd2);

  always_comb begin
    s_axis_tready = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE, S_HDR, S_DRAIN: s_axis_tready = 1'b1;
        S_PAY:                  s_axis_tready = pay_room;
        default:                s_axis_tready = 1'b0;
      endcase
    end
  end

  assign in_fire = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      hdr_vld_q   <= 1'b0;
      dw_idx_q    <= 2'd0;
      hdr4_q      <= 1'b0;
      has_data_q  <= 1'b0;
      hdr_last_q  <= 1'b0;
      rem_q       <= 11'd0;
      pay_vld_q   <= 1'b0;
      pay_last_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      err_len_q   <= 1'b0;
      err_trunc_q <= 1'b0;
      // Output slot empties on handshake; refilled below if PAY accepts a beat.
      if (out_fire) pay_vld_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            hdr_q      <= {s_axis_tdata, 96'd0};
            hdr4_q     <= s_axis_tdata[29];
            has_data_q <= s_axis_tdata[30];
            rem_q      <= len_to_dw(s_axis_tdata[9:0]);
            dw_idx_q   <= 2'd1;
            // A single-DW packet cannot hold a header.
            if (s_axis_tlast) err_trunc_q <= 1'b1;
            else              state_q     <= S_HDR;
          end
        end

        S_HDR: begin
          if (in_fire) begin
            case (dw_idx_q)
              2'd1:    hdr_q[95:64] <= s_axis_tdata;
              2'd2:    hdr_q[63:32] <= s_axis_tdata;
              default: hdr_q[31:0]  <= s_axis_tdata;
            endcase
            if (hdr_final) begin
              hdr_vld_q  <= 1'b1;
              hdr_last_q <= s_axis_tlast;
              state_q    <= S_HOUT;
            end else if (s_axis_tlast) begin
              err_trunc_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              dw_idx_q <= dw_idx_q + 2'd1;
            end
          end
        end

        S_HOUT: begin
          if (m_hdr_ready) begin
            hdr_vld_q <= 1'b0;
            if (has_data_q && !hdr_last_q) begin
              state_q <= S_PAY;
            end else if (has_data_q) begin
              err_len_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (hdr_last_q) begin
              state_q <= S_IDLE;
            end else begin
              err_len_q <= 1'b1;
              state_q   <= S_DRAIN;
            end
          end
        end

        S_PAY: begin
          if (in_fire) begin
            pay_data_q <= s_axis_tdata;
            pay_vld_q  <= 1'b1;
            pay_last_q <= (rem_q == 11'd1) || s_axis_tlast;
            rem_q      <= rem_q - 11'd1;
            if (rem_q == 11'd1) begin
              if (s_axis_tlast) begin
                state_q <= S_IDLE;
              end else begin
                err_len_q <= 1'b1;
                state_q   <= S_DRAIN;
              end
            end else if (s_axis_tlast) begin
              err_len_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end

        S_DRAIN: begin
          if (in_fire && s_axis_tlast) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_hdr         = hdr_q;
  assign m_hdr_valid   = hdr_vld_q;
  assign m_axis_tdata  = pay_data_q;
  assign m_axis_tvalid = pay_vld_q;
  assign m_axis_tlast  = pay_last_q;
  assign err_len       = err_len_q;
  assign err_trunc     = err_trunc_q;

endmodule

// File: tb/tb_pcie_tlp_hdr_extract.sv
// Directed testbench for pcie_tlp_hdr_extract. Each scenario task drives a
// packet and compares the recorded header/payload/error activity against
// hand-computed values.
module tb_pcie_tlp_hdr_extract;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [127:0] m_hdr;
  logic         m_hdr_valid;
  logic         m_hdr_ready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         err_len;
  logic         err_trunc;

  int errors = 0;
  int checks = 0;
  logic rnd_en = 1'b0;

  logic [127:0] hq[$];
  logic [31:0]  pd[$];
  logic         pl[$];
  int n_len = 0;
  int n_trunc = 0;
  int hv_cyc = 0;

  always #5 clk = ~clk;

  pcie_tlp_hdr_extract dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_hdr         (m_hdr),
    .m_hdr_valid   (m_hdr_valid),
    .m_hdr_ready   (m_hdr_ready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .err_len       (err_len),
    .err_trunc     (err_trunc)
  );

  // Downstream readiness changes shortly after each rising edge.
  initial begin
    m_tready    = 1'b1;
    m_hdr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rnd_en) begin
        m_tready    = ($urandom_range(0, 1) != 0);
        m_hdr_ready = ($urandom_range(0, 1) != 0);
      end else begin
        m_tready    = 1'b1;
        m_hdr_ready = 1'b1;
      end
    end
  end

  // Monitor: records handshakes and error pulses between clock edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_hdr_valid) hv_cyc++;
      if (m_hdr_valid && m_hdr_ready) hq.push_back(m_hdr);
      if (m_tvalid && m_tready) begin
        pd.push_back(m_tdata);
        pl.push_back(m_tlast);
      end
      if (err_len)   n_len++;
      if (err_trunc) n_trunc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Drive one beat; returns at the falling edge after it was accepted.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    logic acc;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 2000) begin
      #1;
      acc = s_tready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    @(negedge clk);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    repeat (3) @(negedge clk);
    checks++; if (m_hdr !== 128'd0) begin errors++; $display("FAIL rst_hdr: got %h want 0", m_hdr); end
    checks++; if (m_hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_hdr_valid: got %b want 0", m_hdr_valid); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len: got %b want 0", err_len); end
    checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL rst_err_trunc: got %b want 0", err_trunc); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_tready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got %b want 1", s_tready); end
  endtask

  task automatic test_mrd3();
    int h0, p0, l0, t0, v0;
    h0 = hq.size(); p0 = pd.size(); l0 = n_len; t0 = n_trunc; v0 = hv_cyc;
    send_beat(32'h00000001, 1'b0);
    send_beat(32'h0000000F, 1'b0);
    send_beat(32'h12340000, 1'b1);
    idle(6);
    checks++; if (hq.size() !== h0 + 1) begin errors++; $display("FAIL mrd3_hdr_count: got %0d want 1", hq.size() - h0); end
    else begin
      checks++;
      if (hq[h0] !== 128'h00000001_0000000F_12340000_00000000) begin
        errors++; $display("FAIL mrd3_hdr: got %h want 00000001_0000000F_12340000_00000000", hq[h0]);
      end
    end
    checks++; if (hv_cyc - v0 !== 1) begin errors++; $display("FAIL mrd3_hvalid_cycles: got %0d want 1", hv_cyc - v0); end
    checks++; if (pd.size() !== p0) begin errors++; $display("FAIL mrd3_payload: got %0d beats want 0", pd.size() - p0); end
    checks++; if (n_len !== l0 || n_trunc !== t0) begin errors++; $display("FAIL mrd3_errs: got len=%0d trunc=%0d want 0/0", n_len - l0, n_trunc - t0); end
  endtask

  task automatic test_mwr4();
    int h0, p0, l0, t0;
    h0 = hq.size(); p0 = pd.size(); l0 = n_len; t0 = n_trunc;
    send_beat(32'h60000002, 1'b0);
    send_beat(32'h0000000F, 1'b0);
    send_beat(32'hAABBCCDD, 1'b0);
    send_beat(32'h11223340, 1'b0);
    send_beat(32'hDEADBEEF, 1'b0);
    send_beat(32'hCAFEF00D, 1'b1);
    idle(6);
    checks++; if (hq.size() !== h0 + 1) begin errors++; $display("FAIL mwr4_hdr_count: got %0d want 1", hq.size() - h0); end
    else begin
      checks++;
      if (hq[h0] !== 128'h60000002_0000000F_AABBCCDD_11223340) begin
        errors++; $display("FAIL mwr4_hdr: got %h want 60000002_0000000F_AABBCCDD_11223340", hq[h0]);
      end
    end
    checks++; if (pd.size() !== p0 + 2) begin errors++; $display("FAIL mwr4_beats: got %0d want 2", pd.size() - p0); end
    else begin
      checks++; if (pd[p0] !== 32'hDEADBEEF || pl[p0] !== 1'b0) begin errors++; $display("FAIL mwr4_beat0: got %h last=%b want deadbeef last=0", pd[p0], pl[p0]); end
      checks++; if (pd[p0+1] !== 32'hCAFEF00D || pl[p0+1] !== 1'b1) begin errors++; $display("FAIL mwr4_beat1: got %h last=%b want cafef00d last=1", pd[p0+1], pl[p0+1]); end
    end
    checks++; if (n_len !== l0 || n_trunc !== t0) begin errors++; $display("FAIL mwr4_errs: got len=%0d trunc=%0d want 0/0", n_len - l0, n_trunc - t0); end
  endtask

  task automatic test_long();
    int p0, l0;
    p0 = pd.size(); l0 = n_len;
    send_beat(32'h4A000001, 1'b0);
    send_beat(32'h00000020, 1'b0);
    send_beat(32'h00000040, 1'b0);
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    send_beat(32'h33333333, 1'b1);
    idle(6);
    checks++; if (pd.size() !== p0 + 1) begin errors++; $display("FAIL long_beats: got %0d want 1", pd.size() - p0); end
    else begin
      checks++; if (pd[p0] !== 32'h11111111 || pl[p0] !== 1'b1) begin errors++; $display("FAIL long_beat0: got %h last=%b want 11111111 last=1", pd[p0], pl[p0]); end
    end
    checks++; if (n_len - l0 !== 1) begin errors++; $display("FAIL long_err_len: got %0d pulses want 1", n_len - l0); end
    test_mrd3();
  endtask

  task automatic test_short();
    int p0, l0;
    p0 = pd.size(); l0 = n_len;
    send_beat(32'h40000004, 1'b0);
    send_beat(32'h0000000F, 1'b0);
    send_beat(32'h00001000, 1'b0);
    send_beat(32'hA1A1A1A1, 1'b0);
    send_beat(32'hA2A2A2A2, 1'b1);
    idle(6);
    checks++; if (pd.size() !== p0 + 2) begin errors++; $display("FAIL short_beats: got %0d want 2", pd.size() - p0); end
    else begin
      checks++; if (pd[p0] !== 32'hA1A1A1A1 || pl[p0] !== 1'b0) begin errors++; $display("FAIL short_beat0: got %h last=%b want a1a1a1a1 last=0", pd[p0], pl[p0]); end
      checks++; if (pd[p0+1] !== 32'hA2A2A2A2 || pl[p0+1] !== 1'b1) begin errors++; $display("FAIL short_beat1: got %h last=%b want a2a2a2a2 last=1", pd[p0+1], pl[p0+1]); end
    end
    checks++; if (n_len - l0 !== 1) begin errors++; $display("FAIL short_err_len: got %0d pulses want 1", n_len - l0); end
  endtask

  task automatic test_trunc();
    int h0, t0, v0;
    h0 = hq.size(); t0 = n_trunc; v0 = hv_cyc;
    send_beat(32'h60000001, 1'b0);
    send_beat(32'h0000000F, 1'b1);
    idle(6);
    checks++; if (n_trunc - t0 !== 1) begin errors++; $display("FAIL trunc_err: got %0d pulses want 1", n_trunc - t0); end
    checks++; if (hv_cyc !== v0 || hq.size() !== h0) begin errors++; $display("FAIL trunc_hvalid: got %0d valid cycles want 0", hv_cyc - v0); end
    test_mrd3();
  endtask

  task automatic test_len0_bp();
    int h0, p0, l0, n;
    h0 = hq.size(); p0 = pd.size(); l0 = n_len;
    rnd_en = 1'b1;
    send_beat(32'h60000000, 1'b0);
    send_beat(32'h00000001, 1'b0);
    send_beat(32'h00000002, 1'b0);
    send_beat(32'h00000003, 1'b0);
    for (int i = 0; i < 1024; i++) send_beat(32'h10000000 + i, (i == 1023));
    s_tvalid = 1'b0;
    n = 0;
    while (pd.size() < p0 + 1024 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rnd_en = 1'b0;
    idle(6);
    checks++; if (hq.size() !== h0 + 1) begin errors++; $display("FAIL len0_hdr_count: got %0d want 1", hq.size() - h0); end
    else begin
      checks++; if (hq[h0] !== 128'h60000000_00000001_00000002_00000003) begin errors++; $display("FAIL len0_hdr: got %h want 60000000_00000001_00000002_00000003", hq[h0]); end
    end
    checks++; if (pd.size() !== p0 + 1024) begin errors++; $display("FAIL len0_beats: got %0d want 1024", pd.size() - p0); end
    else begin
      for (int i = 0; i < 1024; i++) begin
        checks++;
        if (pd[p0+i] !== 32'h10000000 + i || pl[p0+i] !== (i == 1023)) begin
          errors++; $display("FAIL len0_beat%0d: got %h last=%b want %h last=%b", i, pd[p0+i], pl[p0+i], 32'h10000000 + i, (i == 1023));
        end
      end
    end
    checks++; if (n_len !== l0) begin errors++; $display("FAIL len0_err_len: got %0d pulses want 0", n_len - l0); end
  endtask

  task automatic test_reset_mid();
    int l0, t0;
    send_beat(32'h60000004, 1'b0);
    send_beat(32'h00000011, 1'b0);
    send_beat(32'h00000022, 1'b0);
    send_beat(32'h00000033, 1'b0);
    send_beat(32'hBEEF0001, 1'b0);
    send_beat(32'hBEEF0002, 1'b0);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (m_hdr !== 128'd0 || m_hdr_valid !== 1'b0) begin errors++; $display("FAIL midrst_hdr: got %h valid=%b want 0/0", m_hdr, m_hdr_valid); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL midrst_axis: got tvalid=%b tlast=%b want 0/0", m_tvalid, m_tlast); end
    checks++; if (err_len !== 1'b0 || err_trunc !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL midrst_ctl: got len=%b trunc=%b tready=%b want 0/0/0", err_len, err_trunc, s_tready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    l0 = n_len; t0 = n_trunc;
    test_mwr4();
    checks++; if (n_len !== l0 || n_trunc !== t0) begin errors++; $display("FAIL midrst_errs: got len=%0d trunc=%0d want 0/0", n_len - l0, n_trunc - t0); end
  endtask

  task automatic test_back_to_back();
    int h0, p0, l0;
    h0 = hq.size(); p0 = pd.size(); l0 = n_len;
    send_beat(32'h60000002, 1'b0);
    send_beat(32'h0000000F, 1'b0);
    send_beat(32'hAABBCCDD, 1'b0);
    send_beat(32'h11223340, 1'b0);
    send_beat(32'h01010101, 1'b0);
    send_beat(32'h02020202, 1'b1);
    send_beat(32'h00000001, 1'b0);
    send_beat(32'h0000000F, 1'b0);
    send_beat(32'h12340000, 1'b1);
    idle(6);
    checks++; if (hq.size() !== h0 + 2) begin errors++; $display("FAIL b2b_hdr_count: got %0d want 2", hq.size() - h0); end
    else begin
      checks++; if (hq[h0+1] !== 128'h00000001_0000000F_12340000_00000000) begin errors++; $display("FAIL b2b_hdr2: got %h want 00000001_0000000F_12340000_00000000", hq[h0+1]); end
    end
    checks++; if (pd.size() !== p0 + 2) begin errors++; $display("FAIL b2b_beats: got %0d want 2", pd.size() - p0); end
    else begin
      checks++; if (pd[p0+1] !== 32'h02020202 || pl[p0+1] !== 1'b1) begin errors++; $display("FAIL b2b_beat1: got %h last=%b want 02020202 last=1", pd[p0+1], pl[p0+1]); end
    end
    checks++; if (n_len !== l0) begin errors++; $display("FAIL b2b_err_len: got %0d pulses want 0", n_len - l0); end
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    @(negedge clk);
    test_reset();
    test_mrd3();
    test_mwr4();
    test_long();
    test_short();
    test_trunc();
    test_len0_bp();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
